// File: rtl/instr_encoder_pkg.sv
// Shared MIPS-subset encoding constants: mnemonic kinds, opcodes, funct codes.
// Used by the instruction encoder and by the main decoder.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        KIND_ADD = 4'd0,
        KIND_SUB = 4'd1,
        KIND_ORI = 4'd2,
        KIND_LW  = 4'd3,
        KIND_SW  = 4'd4,
        KIND_BEQ = 4'd5,
        KIND_LUI = 4'd6,
        KIND_JAL = 4'd7,
        KIND_JR  = 4'd8
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Codes above KIND_JR have no encoding.
    function automatic logic kind_legal(input logic [3:0] k);
        return k <= KIND_JR;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
// master = request producer / word consumer, slave = the encoder.
interface instr_encoder_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_kind;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [25:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_addr;
    logic [CW-1:0] count;
    logic          err;
    logic          err_clr;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready, err_clr,
        input  in_ready, out_valid, out_instr, out_addr, count, err
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready, err_clr,
        output in_ready, out_valid, out_instr, out_addr, count, err
    );
endinterface

// File: rtl/instr_encoder_enc_fifo.sv
// Small synchronous FIFO with occupancy count. Head reads as zero when empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    // A full FIFO refuses pushes even on a simultaneous pop (no pass-through).
    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = o_empty ? '0 : r_mem[r_rd];
    assign o_count   = r_count;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder: encodes accepted requests into 32-bit words,
// queues them, and pairs each emitted word with its instruction byte address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] ADDR_BASE = 32'h0000_3000,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    instr_encoder_if.slave bus
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   w_instr;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_accept;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   r_addr;
    logic          r_err;

    assign bus.in_ready  = (w_count != FULL_CNT);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_legal       = kind_legal(bus.in_kind);
    assign w_push        = w_accept && w_legal;
    assign w_pop         = bus.out_ready && !w_empty;
    assign bus.out_valid = !w_empty;
    assign bus.count     = w_count;
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err;

    // Field packing per mnemonic; jr zeroes rt/rd, lui zeroes rs.
    always_comb begin
        w_instr = '0;
        case (bus.in_kind)
            KIND_ADD: w_instr = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_ADD};
            KIND_SUB: w_instr = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, FN_SUB};
            KIND_ORI: w_instr = {OP_ORI, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            KIND_LW:  w_instr = {OP_LW,  bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            KIND_SW:  w_instr = {OP_SW,  bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            KIND_BEQ: w_instr = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            KIND_LUI: w_instr = {OP_LUI, 5'b0, bus.in_rt, bus.in_imm[15:0]};
            KIND_JAL: w_instr = {OP_JAL, bus.in_imm};
            KIND_JR:  w_instr = {OP_RTYPE, bus.in_rs, 5'b0, 5'b0, 5'b0, FN_JR};
            default:  w_instr = '0;
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_instr),
        .o_dout  (bus.out_instr),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Address of the head word; advances only on a real output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_addr <= ADDR_BASE;
        else if (w_pop) r_addr <= r_addr + 32'd4;
    end

    // Sticky illegal-kind flag; a new illegal acceptance beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= 1'b0;
        else if (w_accept && !w_legal) r_err <= 1'b1;
        else if (bus.err_clr) r_err <= 1'b0;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed encoding vectors, back-pressure, error flag,
// mid-stream reset, then randomized traffic against a queue-based model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(DEPTH)) bus_if ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        string       name;
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [25:0] imm;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [31:0] m_addr;
    logic        m_err;
    bit          last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fields(input logic [31:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [31:0] low);
        return op * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + low;
    endfunction

    // Word value from the mnemonic rules, built with plain arithmetic.
    function automatic logic [31:0] m_encode(input logic [3:0] k, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [25:0] imm);
        logic [31:0] i16;
        i16 = 32'(imm) % 32'd65536;
        case (k)
            4'd0: return fields(0, rs, rt, 32'(rd) * 32'd2048 + 32);
            4'd1: return fields(0, rs, rt, 32'(rd) * 32'd2048 + 34);
            4'd2: return fields(13, rs, rt, i16);
            4'd3: return fields(35, rs, rt, i16);
            4'd4: return fields(43, rs, rt, i16);
            4'd5: return fields(4, rs, rt, i16);
            4'd6: return fields(15, 0, rt, i16);
            4'd7: return 32'd3 * 32'd67108864 + 32'(imm);
            4'd8: return fields(0, rs, 0, 8);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm);
        bus_if.in_kind = k; bus_if.in_rs = rs; bus_if.in_rt = rt;
        bus_if.in_rd = rd; bus_if.in_imm = imm;
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = BASE;
        m_err = 1'b0;
    endtask

    // One clock: model decides handshakes from pre-edge state, DUT sampled at +1.
    task automatic tick();
        bit acc, pop;
        acc = bus_if.in_valid && (q.size() < DEPTH);
        pop = bus_if.out_ready && (q.size() > 0);
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            m_addr = m_addr + 32'd4;
        end
        if (acc && bus_if.in_kind <= 4'd8)
            q.push_back(m_encode(bus_if.in_kind, bus_if.in_rs, bus_if.in_rt, bus_if.in_rd, bus_if.in_imm));
        if (acc && bus_if.in_kind > 4'd8) m_err = 1'b1;
        else if (bus_if.err_clr) m_err = 1'b0;
        last_acc = acc;
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},     32'(bus_if.count), 32'(q.size()));
        chk({tag, ".in_ready"},  32'(bus_if.in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(q.size() > 0));
        chk({tag, ".out_instr"}, bus_if.out_instr, (q.size() > 0) ? q[0] : 32'h0);
        chk({tag, ".out_addr"},  bus_if.out_addr, m_addr);
        chk({tag, ".err"},       32'(bus_if.err), 32'(m_err));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        bus_if.in_valid = 0; bus_if.out_ready = 0; bus_if.err_clr = 0;
        drive(0, 0, 0, 0, 0);
        model_reset();

        vecs[0] = '{"add",  4'd0, 5'd1,  5'd2, 5'd3, 26'h0,       32'h0022_1820};
        vecs[1] = '{"ori",  4'd2, 5'd0,  5'd8, 5'd7, 26'h3FF1234, 32'h3408_1234};
        vecs[2] = '{"lui",  4'd6, 5'd5,  5'd1, 5'd0, 26'h000FFFF, 32'h3C01_FFFF};
        vecs[3] = '{"beq",  4'd5, 5'd1,  5'd2, 5'd0, 26'h000FFFF, 32'h1022_FFFF};
        vecs[4] = '{"jal",  4'd7, 5'd9,  5'd9, 5'd9, 26'h0000C00, 32'h0C00_0C00};
        vecs[5] = '{"jr",   4'd8, 5'd31, 5'd7, 5'd9, 26'h0,       32'h03E0_0008};
        vecs[6] = '{"sub",  4'd1, 5'd4,  5'd5, 5'd6, 26'h0,       32'h0085_3022};
        vecs[7] = '{"sw",   4'd4, 5'd29, 5'd9, 5'd0, 26'h000FFFC, 32'hAFA9_FFFC};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset.addr_base", bus_if.out_addr, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Encoding table: accept, see word one cycle later, consume it
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
            bus_if.in_valid = 1;
            tick();
            bus_if.in_valid = 0;
            chk({vecs[i].name, ".vld"},  32'(bus_if.out_valid), 32'd1);
            chk({vecs[i].name, ".word"}, bus_if.out_instr, vecs[i].exp);
            chk({vecs[i].name, ".addr"}, bus_if.out_addr, BASE + 32'(4 * i));
            check_state(vecs[i].name);
            bus_if.out_ready = 1;
            tick();
            bus_if.out_ready = 0;
            check_state({vecs[i].name, ".pop"});
        end

        // Back-pressure: fill to DEPTH, hold the 5th, drain in order
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 5'd1, 5'd2, 5'(i + 10), 0);
            bus_if.in_valid = 1;
            tick();
            check_state("bp.fill");
        end
        drive(0, 5'd1, 5'd2, 5'd14, 0);
        repeat (2) begin
            tick();
            chk("bp.held_acc", 32'(last_acc), 32'd0);
            chk("bp.full_count", 32'(bus_if.count), 32'd4);
            chk("bp.in_ready_low", 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.drain_vld", 32'(bus_if.out_valid), 32'd1);
            chk("bp.drain_addr", bus_if.out_addr, 32'h3000 + 32'(4 * i));
            chk("bp.drain_word", bus_if.out_instr, 32'h0022_0020 + 32'(i + 10) * 32'd2048);
            check_state("bp.drain");
            tick();
            if (last_acc) bus_if.in_valid = 0;
        end
        chk("bp.empty", 32'(bus_if.out_valid), 32'd0);
        tick();
        check_state("bp.idle_no_advance");
        bus_if.out_ready = 0;

        // Illegal kind, clear, then clear racing a new illegal request
        drive(4'd15, 5'd3, 5'd3, 5'd3, 26'h1);
        bus_if.in_valid = 1;
        tick();
        bus_if.in_valid = 0;
        chk("ill.err", 32'(bus_if.err), 32'd1);
        chk("ill.count", 32'(bus_if.count), 32'd0);
        check_state("ill");
        bus_if.err_clr = 1;
        tick();
        bus_if.err_clr = 0;
        chk("clr.err", 32'(bus_if.err), 32'd0);
        bus_if.in_valid = 1;
        tick();
        bus_if.in_valid = 0;
        bus_if.err_clr = 1;
        bus_if.in_valid = 1;
        drive(4'd9, 0, 0, 0, 0);
        tick();
        bus_if.err_clr = 0;
        bus_if.in_valid = 0;
        chk("clr_race.err", 32'(bus_if.err), 32'd1);
        check_state("clr_race");

        // Reset with 3 queued entries
        for (int i = 0; i < 3; i++) begin
            drive(4'd3, 5'd29, 5'(i), 0, 26'(i * 4));
            bus_if.in_valid = 1;
            tick();
        end
        bus_if.in_valid = 0;
        chk("pre_rst.count", 32'(bus_if.count), 32'd3);
        reset = 1'b0;
        #1;
        chk("rst.count", 32'(bus_if.count), 32'd0);
        chk("rst.vld", 32'(bus_if.out_valid), 32'd0);
        chk("rst.instr", bus_if.out_instr, 32'h0);
        chk("rst.addr", bus_if.out_addr, 32'h3000);
        chk("rst.err", 32'(bus_if.err), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(4'd2, 5'd0, 5'd8, 0, 26'h1234);
        bus_if.in_valid = 1;
        tick();
        bus_if.in_valid = 0;
        chk("post_rst.addr", bus_if.out_addr, 32'h3000);
        chk("post_rst.word", bus_if.out_instr, 32'h3408_1234);
        check_state("post_rst");

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            bus_if.in_valid  = ($urandom_range(0, 2) != 0);
            bus_if.out_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            bus_if.err_clr   = ($urandom_range(0, 9) == 0);
            drive(($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                  5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
            tick();
            check_state("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the single-cycle MIPS subset: add, sub, ori, lw, sw, beq, lui, jal, jr. It takes a mnemonic code plus register and immediate fields over a valid/ready input. It emits the 32-bit machine word, with its instruction-memory byte address, through a small FIFO and a valid/ready output. It sits in the test and program-load path, generating instruction words that the main decoder later consumes.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_BASE, 32'h0000_3000: byte address of the first emitted word.
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  4  mnemonic code: 0 add, 1 sub, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 jal, 8 jr; 9–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  26  immediate: bits [15:0] for I-type, all 26 bits for jal.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  head consumed when out_valid && out_ready.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  32  byte address paired with out_instr.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky illegal-kind flag.
- err_clr  in  1  clears err.

## Operation
Encoding is combinational on the accepted request and written into the FIFO. Field layouts:
- R-type (add/sub/jr): {6'h00, rs, rt, rd, 5'b0, funct}.
  - funct: add 6'h20, sub 6'h22, jr 6'h08.
  - jr forces rt = 0 and rd = 0.
- I-type: {op, rs, rt, imm[15:0]}.
  - op: ori 6'h0D, lw 6'h23, sw 6'h2B, beq 6'h04, lui 6'h0F.
  - lui forces rs = 0.
- jal: {6'h03, imm[25:0]}.

Illegal kind:
- The request is still accepted, subject to in_ready.
- Nothing is enqueued; count is unchanged.
- err is set. It stays set until err_clr.
- If err_clr and a new illegal request are accepted in the same cycle, the set wins.

Flow control:
- in_ready = (count < DEPTH). It does not depend on out_ready, so there is no pass-through when full.
- Simultaneous push and pop leave count unchanged; contents advance in order.
- out_instr = 32'h0 whenever out_valid = 0.

Addressing:
- An address register starts at ADDR_BASE and increments by 4 on every output handshake.
- It wraps modulo 2^32.
- out_addr always shows the current register value.

## Timing
- Reset asserted:
  - count 0, out_valid 0, out_instr 0.
  - out_addr = ADDR_BASE, err 0, in_ready 1.
  - Asynchronous entry; release is synchronous to clk.
- Latency: a word accepted at edge N is visible with out_valid = 1 after edge N; it can be consumed at edge N+1.
- Throughput: 1 word/cycle when both sides are ready.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Empty: out_valid = 0. out_ready is ignored and out_addr does not advance.
- err is set the cycle after an illegal acceptance.
- Reset mid-stream discards all FIFO contents and restarts out_addr at ADDR_BASE.

## Structure
- Shared package holds:
  - kind codes (KIND_ADD..KIND_JR);
  - opcode constants (OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_JAL);
  - funct constants (FN_ADD, FN_SUB, FN_JR).
- The main decoder uses the same package.
- One sub-module: enc_fifo, a parameterized synchronous FIFO with push/pop/count. The encoder mux and the address counter stay in instr_encoder.

## Test plan
- add, rs=1 rt=2 rd=3 -> out_instr 32'h00221820, out_addr 32'h3000, out_valid the cycle after acceptance.
- ori rs=0 rt=8 imm=16'h1234 -> 32'h34081234.
- lui rs=5 rt=1 imm=16'hFFFF -> 32'h3C01FFFF (rs forced 0).
- beq rs=1 rt=2 imm=16'hFFFF -> 32'h1022FFFF.
- jal imm=26'h0000C00 -> 32'h0C000C00.
- jr rs=31 with nonzero rt/rd -> 32'h03E00008.
- Back-pressure: out_ready=0 and 5 requests offered (DEPTH=4).
  - count reaches 4 and in_ready goes low; the 5th request is held.
  - Then out_ready=1: words drain in order at 32'h3000, 3004, 3008, 300C, then the 5th word at 3010.
- Illegal kind=15 -> err=1, count unchanged, no output.
- err_clr -> err=0.
- err_clr together with another illegal request -> err stays 1.
- Reset asserted with 3 entries queued -> count 0, out_valid 0, next word emitted at 32'h3000.
